// File: rtl/uart_reg_master_pkg.sv
// uart_reg_master_pkg: register map, op codes and FSM states for uart_reg_master
package uart_reg_master_pkg;
  typedef enum logic [1:0] {IDLE, POLL, ACCESS, RESP} state_t;
  localparam logic [1:0] OP_TX  = 2'b00;
  localparam logic [1:0] OP_RX  = 2'b01;
  localparam logic [1:0] OP_CFG = 2'b10;
  localparam logic [1:0] REG_CR  = 2'd0;
  localparam logic [1:0] REG_SR  = 2'd1;
  localparam logic [1:0] REG_TDR = 2'd2;
  localparam logic [1:0] REG_RDR = 2'd3;
  localparam int CHAN_STRIDE = 4;
  function automatic logic [21:0] reg_addr(input logic chan, input logic [1:0] off);
    return 22'(chan) * 22'(CHAN_STRIDE) + 22'(off);
  endfunction
endpackage

// File: rtl/uart_reg_master.sv
// uart_reg_master: polled CR/SR/TDR/RDR bus initiator for the dual-UART register file
// Define UART_MASTER_CFG_EN to enable op 10 (write CRx); otherwise op 10 is reserved.
module uart_reg_master
  import uart_reg_master_pkg::*;
#(
  parameter int POLL_LIMIT   = 1024,
  parameter int TX_FULL_BIT  = 1,
  parameter int RX_AVAIL_BIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_chan,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic [21:0] addr,
  output logic        we,
  output logic        re,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);
  localparam int CW = $clog2(POLL_LIMIT) + 1;
`ifdef UART_MASTER_CFG_EN
  localparam bit CFG_EN = 1'b1;
`else
  localparam bit CFG_EN = 1'b0;
`endif
  state_t state, state_nx;
  logic [1:0] op;
  logic chan;
  logic [31:0] data;
  logic [CW-1:0] cnt;
  logic accept, cmd_legal, sr_ready, timeout, unused_rd;
  assign cmd_ready = state == IDLE && !rst;
  assign accept = cmd_valid && cmd_ready;
  assign cmd_legal = cmd_op == OP_TX || cmd_op == OP_RX || (CFG_EN && cmd_op == OP_CFG);
  assign sr_ready = op == OP_TX ? !read_data[TX_FULL_BIT] : read_data[RX_AVAIL_BIT];
  assign timeout = cnt == CW'(POLL_LIMIT - 1);
  assign rsp_valid = state == RESP;
  assign unused_rd = ^read_data;
  always_comb begin
    state_nx = state;
    we = 1'b0;
    re = 1'b0;
    addr = '0;
    write_data = '0;
    case (state)
      IDLE: state_nx = !accept ? IDLE : !cmd_legal ? RESP : cmd_op == OP_CFG ? ACCESS : POLL;
      POLL: begin
        re = 1'b1;
        addr = reg_addr(chan, REG_SR);
        state_nx = sr_ready ? ACCESS : timeout ? RESP : POLL;
      end
      ACCESS: begin
        state_nx = RESP;
        we = op != OP_RX;
        re = op == OP_RX;
        addr = reg_addr(chan, op == OP_TX ? REG_TDR : op == OP_RX ? REG_RDR : REG_CR);
        write_data = op == OP_TX ? {24'h0, data[7:0]} : op == OP_CFG ? data : '0;
      end
      RESP: state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op <= OP_TX;
      chan <= 1'b0;
      data <= '0;
      cnt <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op <= cmd_op;
        chan <= cmd_chan;
        data <= cmd_data;
        cnt <= '0;
        rsp_data <= '0;
        rsp_err <= !cmd_legal;
      end
      // a failed poll on the last allowed read ends the command with an error
      if (state == POLL && !sr_ready) begin
        cnt <= cnt + CW'(1);
        if (timeout) rsp_err <= 1'b1;
      end
      if (state == ACCESS && op == OP_RX) rsp_data <= read_data[7:0];
    end
  end
endmodule

// File: tb/tb_uart_reg_master.sv
// tb_uart_reg_master: randomized commands against a transaction-level model of the register master
module tb_uart_reg_master;
  localparam int PL = 6;
`ifdef UART_MASTER_CFG_EN
  localparam bit CFG_EN = 1'b1;
`else
  localparam bit CFG_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_chan = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [31:0] cmd_data = '0, write_data, read_data = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err, we, re;
  logic [7:0] rsp_data;
  logic [21:0] addr;

  uart_reg_master #(.POLL_LIMIT(PL), .TX_FULL_BIT(1), .RX_AVAIL_BIT(0)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_chan(cmd_chan), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .addr(addr), .we(we), .re(re),
    .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; bit w; logic [21:0] a; logic [31:0] d;} ev_t;
  ev_t evq[$];
  ev_t obs[$];
  ev_t e;
  int checks = 0, passes = 0;
  int n = 0, acc_n = 0, acc_cnt = 0, hs_cnt = 0, rsp_cyc = 0, rsp_first = -1, mt = 0;
  int force_k = 0;
  logic [31:0] force_rdr = '0, sr;
  bit busy = 0, rsp_pend = 0, just_rst = 0, idle, exp_v, exp_err = 0, hs_err = 0;
  logic [7:0] exp_rd = '0, hs_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [21:0] ra(input logic ch, input int r);
    return 22'(ch) * 22'd4 + 22'(r);
  endfunction

  function automatic int cnt_of(input bit w, input logic [21:0] a);
    int c = 0;
    foreach (obs[i]) if (obs[i].w == w && obs[i].a == a) c++;
    return c;
  endfunction

  task automatic push(input bit w, input logic [21:0] a, input logic [31:0] d);
    evq.push_back('{mt, w, a, d});
    mt++;
  endtask

  // Monitor, register-bank responder and transaction-level model, all at the falling edge
  always @(negedge clk) begin
    n++;
    if (we || re) obs.push_back('{n, we, addr, write_data});
    if (rst) begin
      evq.delete();
      busy = 0;
      rsp_pend = 0;
      just_rst = 1;
      read_data = $urandom;
      chk("cmd_ready_in_rst", 64'(cmd_ready), 64'd0);
    end else begin
      if (just_rst)
        chk("reset_outputs", {rsp_valid, rsp_data, rsp_err, addr, we, re}, '0);
      just_rst = 0;
      if (evq.size() > 0 && evq[0].cyc == n) begin
        e = evq.pop_front();
        chk("bus_event", {we, re, addr, e.w ? write_data : 32'h0},
            {e.w, !e.w, e.a, e.w ? e.d : 32'h0});
        read_data = e.w ? $urandom : e.d;
      end else begin
        chk("bus_idle", {we, re}, 2'b00);
        read_data = $urandom;
      end
      exp_v = rsp_pend && n >= rsp_cyc;
      chk("rsp", {rsp_valid, exp_v ? {rsp_data, rsp_err} : 9'h0},
          {exp_v, exp_v ? {exp_rd, exp_err} : 9'h0});
      if (rsp_valid && rsp_first < 0) rsp_first = n;
      chk("cmd_ready", 64'(cmd_ready), 64'(!busy));
      idle = !busy;
      if (exp_v && rsp_ready) begin
        hs_data = rsp_data;
        hs_err = rsp_err;
        rsp_pend = 0;
        busy = 0;
        hs_cnt++;
      end
      if (idle && cmd_valid) begin
        mt = n + 1;
        exp_rd = '0;
        exp_err = 0;
        if (cmd_op == 2'b00 || cmd_op == 2'b01) begin
          for (int i = 0; i < PL && i <= force_k; i++) begin
            sr = $urandom;
            if (cmd_op == 2'b00) sr[1] = i < force_k;
            else sr[0] = !(i < force_k);
            push(0, ra(cmd_chan, 1), sr);
          end
          if (force_k >= PL) exp_err = 1;
          else if (cmd_op == 2'b00) push(1, ra(cmd_chan, 2), {24'h0, cmd_data[7:0]});
          else begin
            push(0, ra(cmd_chan, 3), force_rdr);
            exp_rd = force_rdr[7:0];
          end
        end else if (CFG_EN && cmd_op == 2'b10) push(1, ra(cmd_chan, 0), cmd_data);
        else exp_err = 1;
        rsp_cyc = mt;
        rsp_pend = 1;
        busy = 1;
        acc_n = n;
        acc_cnt++;
      end
    end
  end

  task automatic cyc(input int m);
    repeat (m) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic ch, input logic [31:0] d,
                       input int k, input logic [31:0] rdr);
    int a0;
    a0 = acc_cnt;
    force_k = k;
    force_rdr = rdr;
    obs.delete();
    rsp_first = -1;
    cmd_valid = 1;
    cmd_op = op;
    cmd_chan = ch;
    cmd_data = d;
    for (int i = 0; i < 200 && acc_cnt == a0; i++) @(posedge clk);
    #1 cmd_valid = 0;
    chk("accept_wait", 64'(acc_cnt != a0), 64'd1);
  endtask

  task automatic wait_rsp(input int hold);
    int h0;
    h0 = hs_cnt;
    rsp_ready = 0;
    repeat (hold) @(posedge clk);
    #1 rsp_ready = 1;
    for (int i = 0; i < 200 && hs_cnt == h0; i++) @(posedge clk);
    #1 rsp_ready = 0;
    chk("rsp_wait", 64'(hs_cnt != h0), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int r, g;
    cyc(3);
    rst = 0;
    @(negedge clk);
    chk("post_reset_ready", {cmd_ready, rsp_valid, we, re, addr}, {1'b1, 25'h0});
    cyc(1);
    // TX ch0, SR ready on first poll
    issue(2'b00, 1'b0, 32'h1234_56A5, 0, 32'h0);
    wait_rsp(0);
    chk("tx_nobs", obs.size(), 2);
    if (obs.size() >= 2) begin
      chk("tx_poll", {obs[0].w, obs[0].a, 32'(obs[0].cyc - acc_n)}, {1'b0, 22'd1, 32'd1});
      chk("tx_write", {obs[1].w, obs[1].a, obs[1].d}, {1'b1, 22'd2, 32'h0000_00A5});
      chk("tx_write_cyc", obs[1].cyc - acc_n, 2);
    end
    chk("tx_rsp_cyc", rsp_first - acc_n, 3);
    chk("tx_err", 64'(hs_err), 64'd0);
    // RX ch1, five busy polls then data
    issue(2'b01, 1'b1, 32'h0, 5, 32'h0000_003C);
    wait_rsp(1);
    chk("rx_sr_reads", cnt_of(0, 22'd5), 6);
    chk("rx_rdr_reads", cnt_of(0, 22'd7), 1);
    chk("rx_data", {hs_data, hs_err}, {8'h3C, 1'b0});
    // TX ch0 with SR stuck full: timeout after PL reads, response held 10 cycles
    issue(2'b00, 1'b0, 32'h77, 100, 32'h0);
    wait_rsp(10);
    chk("to_sr_reads", cnt_of(0, 22'd1), 6);
    chk("to_nobs", obs.size(), 6);
    chk("to_rsp", {hs_data, hs_err}, {8'h00, 1'b1});
    // CFG ch1
    issue(2'b10, 1'b1, 32'h0000_C001, 0, 32'h0);
    wait_rsp(2);
    if (CFG_EN) begin
      chk("cfg_nobs", obs.size(), 1);
      if (obs.size() >= 1) chk("cfg_write", {obs[0].w, obs[0].a, obs[0].d}, {1'b1, 22'd4, 32'h0000_C001});
      chk("cfg_err", 64'(hs_err), 64'd0);
    end else begin
      chk("cfg_nobs", obs.size(), 0);
      chk("cfg_err", 64'(hs_err), 64'd1);
    end
    // reserved op
    issue(2'b11, 1'b0, 32'hFFFF_FFFF, 0, 32'h0);
    wait_rsp(0);
    chk("rsv_rsp", {obs.size(), 32'(rsp_first - acc_n), 31'h0, hs_err}, {32'd0, 32'd1, 32'd1});
    // reset in the middle of polling
    issue(2'b00, 1'b1, 32'h5A, 100, 32'h0);
    cyc(1);
    rst = 1;
    cyc(1);
    rst = 0;
    @(negedge clk);
    chk("rst_mid_poll", {we, re, rsp_valid, cmd_ready}, 4'b0001);
    chk("rst_saw_poll", cnt_of(0, 22'd5) > 0, 1);
    cyc(1);
    // randomized traffic
    for (int c = 0; c < 200; c++) begin
      r = $urandom_range(0, 9);
      issue(r < 4 ? 2'b00 : r < 8 ? 2'b01 : r < 9 ? 2'b10 : 2'b11, 1'($urandom), $urandom,
            $urandom_range(0, PL + 1), $urandom);
      wait_rsp($urandom_range(0, 3));
      g = $urandom_range(0, 2);
      cyc(g);
    end
    cyc(3);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
